// File: rtl/ccu_operation_sequencer_if.sv
// Signal bundle between the CCU register file / result-stream snoop and the
// operation sequencer. The sequencer connects through the slave modport.
interface ccu_operation_sequencer_if #(
    parameter int CNT_WIDTH = 32
);
    logic [CNT_WIDTH-1:0] data_size_rd;
    logic [CNT_WIDTH-1:0] grid_size_rd;
    logic [CNT_WIDTH-1:0] scle_size_rd;
    logic [CNT_WIDTH-1:0] rslt_size_rd;
    logic [CNT_WIDTH-1:0] pckt_size_rd;
    logic                 data_loaded_rd;
    logic                 grid_loaded_rd;
    logic                 scle_loaded_rd;
    logic                 wght_loaded_rd;
    logic                 operation_start_rd;
    logic                 interrupt_abort;
    logic                 interrupt_error;
    logic                 rslt_tvalid;
    logic                 rslt_tready;
    logic                 rslt_tlast;
    logic                 rw_pl2ps_reg_en;
    logic                 rslt_loaded_wr;
    logic                 operation_done_wr;
    logic                 wo_reg_en;
    logic                 wo_reg_rst;
    logic                 operation_status_idle_wr;
    logic                 operation_status_busy_wr;
    logic                 operation_status_error_wr;
    logic                 operation_status_locked_wr;
    logic                 operation_status_valid_wr;
    logic [CNT_WIDTH-1:0] operation_progress_rslt_wr;
    logic [CNT_WIDTH-1:0] operation_progress_iter_wr;
    logic [CNT_WIDTH-1:0] iteration_timer_wr;
    logic [CNT_WIDTH-1:0] iteration_latency_wr;
    logic [CNT_WIDTH-1:0] operation_timer_wr;
    logic [CNT_WIDTH-1:0] operation_latency_wr;

    modport master (
        output data_size_rd, grid_size_rd, scle_size_rd, rslt_size_rd, pckt_size_rd,
        output data_loaded_rd, grid_loaded_rd, scle_loaded_rd, wght_loaded_rd,
        output operation_start_rd, interrupt_abort, interrupt_error,
        output rslt_tvalid, rslt_tready, rslt_tlast,
        input  rw_pl2ps_reg_en, rslt_loaded_wr, operation_done_wr, wo_reg_en, wo_reg_rst,
        input  operation_status_idle_wr, operation_status_busy_wr, operation_status_error_wr,
        input  operation_status_locked_wr, operation_status_valid_wr,
        input  operation_progress_rslt_wr, operation_progress_iter_wr,
        input  iteration_timer_wr, iteration_latency_wr, operation_timer_wr, operation_latency_wr
    );

    modport slave (
        input  data_size_rd, grid_size_rd, scle_size_rd, rslt_size_rd, pckt_size_rd,
        input  data_loaded_rd, grid_loaded_rd, scle_loaded_rd, wght_loaded_rd,
        input  operation_start_rd, interrupt_abort, interrupt_error,
        input  rslt_tvalid, rslt_tready, rslt_tlast,
        output rw_pl2ps_reg_en, rslt_loaded_wr, operation_done_wr, wo_reg_en, wo_reg_rst,
        output operation_status_idle_wr, operation_status_busy_wr, operation_status_error_wr,
        output operation_status_locked_wr, operation_status_valid_wr,
        output operation_progress_rslt_wr, operation_progress_iter_wr,
        output iteration_timer_wr, iteration_latency_wr, operation_timer_wr, operation_latency_wr
    );
endinterface

// File: rtl/ccu_operation_sequencer.sv
// CentralControlUnit operation FSM: validates sizes, waits for loaded buffers,
// counts result packets and writes status/progress/timing back to the register file.
module ccu_operation_sequencer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    ccu_operation_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_STR, S_WAIT_LD, S_RUN, S_DONE, S_ERR
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_reg, state_next;
    logic                 start_d_reg;
    logic                 idle_reg, busy_reg, locked_reg, valid_reg, error_reg;
    logic                 wo_reg_en_reg, wo_reg_rst_reg, rw_en_reg, rslt_loaded_reg, op_done_reg;
    logic [CNT_WIDTH-1:0] prog_rslt_reg, prog_iter_reg;
    logic [CNT_WIDTH-1:0] iter_timer_reg, iter_latency_reg, op_timer_reg, op_latency_reg;

    logic                 start_edge, all_loaded, size_bad, pkt_event, done_entry;
    logic [CNT_WIDTH-1:0] sizes [5];
    logic [4:0]           size_zero;
    logic [CNT_WIDTH:0]   rslt_sum;
    logic [CNT_WIDTH-1:0] prog_rslt_next;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign sizes[0] = bus.data_size_rd;
    assign sizes[1] = bus.grid_size_rd;
    assign sizes[2] = bus.scle_size_rd;
    assign sizes[3] = bus.rslt_size_rd;
    assign sizes[4] = bus.pckt_size_rd;

    for (genvar gi = 0; gi < 5; gi++) begin : g_size_zero
        assign size_zero[gi] = (sizes[gi] == '0);
    end

    // start_d_reg resets high so a start level held through reset is not an edge
    assign start_edge = bus.operation_start_rd & ~start_d_reg;
    assign all_loaded = bus.data_loaded_rd & bus.grid_loaded_rd
                      & bus.scle_loaded_rd & bus.wght_loaded_rd;
    assign size_bad   = (|size_zero) | (bus.pckt_size_rd > bus.rslt_size_rd);
    assign pkt_event  = (state_reg == S_RUN) & bus.rslt_tvalid & bus.rslt_tready & bus.rslt_tlast;
    assign done_entry = (state_next == S_DONE) && (state_reg != S_DONE);

    // One extra bit keeps the sum exact before clamping to the result size
    assign rslt_sum       = {1'b0, prog_rslt_reg} + {1'b0, bus.pckt_size_rd};
    assign prog_rslt_next = (rslt_sum > {1'b0, bus.rslt_size_rd}) ? bus.rslt_size_rd
                                                                   : rslt_sum[CNT_WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start_edge) state_next = S_STR;
            S_STR:     state_next = size_bad ? S_ERR : S_WAIT_LD;
            S_WAIT_LD: if (all_loaded) state_next = S_RUN;
            S_RUN:     if (prog_rslt_reg >= bus.rslt_size_rd) state_next = S_DONE;
            S_DONE:    if (!bus.operation_start_rd) state_next = S_IDLE;
            S_ERR:     if (!bus.operation_start_rd && !bus.interrupt_error) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (bus.interrupt_abort && (state_reg inside {S_STR, S_WAIT_LD, S_RUN}))
            state_next = S_IDLE;
        // error overrides abort
        if (bus.interrupt_error && (state_reg != S_IDLE))
            state_next = S_ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            start_d_reg      <= 1'b1;
            idle_reg         <= 1'b1;
            busy_reg         <= 1'b0;
            locked_reg       <= 1'b0;
            valid_reg        <= 1'b0;
            error_reg        <= 1'b0;
            wo_reg_en_reg    <= 1'b0;
            wo_reg_rst_reg   <= 1'b0;
            rw_en_reg        <= 1'b0;
            rslt_loaded_reg  <= 1'b0;
            op_done_reg      <= 1'b0;
            prog_rslt_reg    <= '0;
            prog_iter_reg    <= '0;
            iter_timer_reg   <= '0;
            iter_latency_reg <= '0;
            op_timer_reg     <= '0;
            op_latency_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            start_d_reg     <= bus.operation_start_rd;
            idle_reg        <= (state_next == S_IDLE);
            busy_reg        <= (state_next inside {S_STR, S_WAIT_LD, S_RUN});
            locked_reg      <= (state_next inside {S_WAIT_LD, S_RUN});
            valid_reg       <= (state_next == S_DONE);
            error_reg       <= (state_next == S_ERR);
            wo_reg_rst_reg  <= (state_next == S_STR);
            wo_reg_en_reg   <= pkt_event | done_entry;
            rw_en_reg       <= done_entry;
            rslt_loaded_reg <= done_entry;
            op_done_reg     <= done_entry;

            if (state_next == S_STR) begin
                prog_rslt_reg    <= '0;
                prog_iter_reg    <= '0;
                iter_timer_reg   <= '0;
                iter_latency_reg <= '0;
                op_timer_reg     <= '0;
                op_latency_reg   <= '0;
            end else begin
                if (state_reg inside {S_WAIT_LD, S_RUN})
                    op_timer_reg <= sat_inc(op_timer_reg);
                if (pkt_event) begin
                    prog_rslt_reg    <= prog_rslt_next;
                    prog_iter_reg    <= sat_inc(prog_iter_reg);
                    iter_latency_reg <= sat_inc(iter_timer_reg);
                    iter_timer_reg   <= '0;
                end else if (state_reg == S_RUN) begin
                    iter_timer_reg <= sat_inc(iter_timer_reg);
                end
                if (done_entry)
                    op_latency_reg <= sat_inc(op_timer_reg);
            end
        end
    end

    assign bus.rw_pl2ps_reg_en            = rw_en_reg;
    assign bus.rslt_loaded_wr             = rslt_loaded_reg;
    assign bus.operation_done_wr          = op_done_reg;
    assign bus.wo_reg_en                  = wo_reg_en_reg;
    assign bus.wo_reg_rst                 = wo_reg_rst_reg;
    assign bus.operation_status_idle_wr   = idle_reg;
    assign bus.operation_status_busy_wr   = busy_reg;
    assign bus.operation_status_error_wr  = error_reg;
    assign bus.operation_status_locked_wr = locked_reg;
    assign bus.operation_status_valid_wr  = valid_reg;
    assign bus.operation_progress_rslt_wr = prog_rslt_reg;
    assign bus.operation_progress_iter_wr = prog_iter_reg;
    assign bus.iteration_timer_wr         = iter_timer_reg;
    assign bus.iteration_latency_wr       = iter_latency_reg;
    assign bus.operation_timer_wr         = op_timer_reg;
    assign bus.operation_latency_wr       = op_latency_reg;
endmodule

// File: tb/tb_ccu_operation_sequencer.sv
// Directed + randomized bench for ccu_operation_sequencer; expected values are
// derived from stimulus timing (cycles spent waiting / between packets) and sizes.
module tb_ccu_operation_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   wo_cnt = 0;
    int   rw_cnt = 0;
    int   gaps [16];

    ccu_operation_sequencer_if #(.CNT_WIDTH(32)) bus ();

    ccu_operation_sequencer #(.CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and tally strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.wo_reg_en === 1'b1) wo_cnt++;
        if (bus.rw_pl2ps_reg_en === 1'b1) rw_cnt++;
    endtask

    task automatic stream(input logic [2:0] v);
        {bus.rslt_tvalid, bus.rslt_tready, bus.rslt_tlast} = v;
    endtask

    // Random stream activity; without allow_full it never forms a packet end.
    task automatic noise(input bit allow_full);
        logic [2:0] v;
        v = 3'($urandom_range(7, 0));
        if (!allow_full && v == 3'b111) v = 3'b011;
        stream(v);
    endtask

    task automatic set_flags(input logic v);
        bus.data_loaded_rd = v; bus.grid_loaded_rd = v;
        bus.scle_loaded_rd = v; bus.wght_loaded_rd = v;
    endtask

    task automatic set_sizes(input logic [31:0] rslt, input logic [31:0] pckt);
        bus.data_size_rd = 32'd4; bus.grid_size_rd = 32'd4; bus.scle_size_rd = 32'd4;
        bus.rslt_size_rd = rslt;  bus.pckt_size_rd = pckt;
    endtask

    task automatic run_op(input longint rslt, input longint pckt, input int wait_n, input bit stagger);
        longint n, exp_prog;
        int wedges, redges, wo0, rw0;
        n = (rslt + pckt - 1) / pckt;
        wo0 = wo_cnt; rw0 = rw_cnt;
        set_sizes(32'(rslt), 32'(pckt));
        bus.operation_start_rd = 1'b1;
        tick();
        chk("str_busy", bus.operation_status_busy_wr, 1);
        chk("str_wo_reg_rst", bus.wo_reg_rst, 1);
        chk("str_prog_clr", bus.operation_progress_rslt_wr, 0);
        tick();
        chk("wait_locked", bus.operation_status_locked_wr, 1);
        chk("wait_wo_reg_rst_low", bus.wo_reg_rst, 0);
        wedges = 0;
        repeat (wait_n) begin noise(1); tick(); wedges++; end
        if (stagger) begin
            stream(3'b111); bus.wght_loaded_rd = 1'b1; tick(); wedges++;
            chk("stag_prog_w", bus.operation_progress_rslt_wr, 0);
            stream(3'b111); bus.scle_loaded_rd = 1'b1; tick(); wedges++;
            chk("stag_prog_s", bus.operation_progress_rslt_wr, 0);
            stream(3'b111); bus.grid_loaded_rd = 1'b1; tick(); wedges++;
            chk("stag_optimer", bus.operation_timer_wr, 32'(wedges));
            stream(3'b111); bus.data_loaded_rd = 1'b1; tick(); wedges++;
        end else begin
            stream(3'b111); set_flags(1'b1); tick(); wedges++;
        end
        stream(3'b000);
        chk("run_entry_optimer", bus.operation_timer_wr, 32'(wedges));
        chk("run_entry_prog", bus.operation_progress_rslt_wr, 0);
        chk("run_entry_iter", bus.operation_progress_iter_wr, 0);
        redges = 0;
        for (int k = 1; k <= int'(n); k++) begin
            repeat (gaps[k-1]) begin noise(0); tick(); redges++; end
            stream(3'b111); tick(); redges++; stream(3'b000);
            exp_prog = (longint'(k) * pckt > rslt) ? rslt : longint'(k) * pckt;
            $display("pkt %0d: rslt=%0d pckt=%0d gap=%0d prog=%0d iter=%0d lat=%0d", k, rslt, pckt,
                     gaps[k-1], bus.operation_progress_rslt_wr, bus.operation_progress_iter_wr,
                     bus.iteration_latency_wr);
            chk("pkt_prog_rslt", bus.operation_progress_rslt_wr, 32'(exp_prog));
            chk("pkt_prog_iter", bus.operation_progress_iter_wr, 32'(k));
            chk("pkt_iter_latency", bus.iteration_latency_wr, 32'(gaps[k-1] + 1));
            chk("pkt_iter_timer", bus.iteration_timer_wr, 0);
            chk("pkt_wo_reg_en", bus.wo_reg_en, 1);
        end
        tick(); redges++;
        chk("done_valid", bus.operation_status_valid_wr, 1);
        chk("done_busy", bus.operation_status_busy_wr, 0);
        chk("done_rw_en", bus.rw_pl2ps_reg_en, 1);
        chk("done_flag", bus.operation_done_wr, 1);
        chk("done_rslt_loaded", bus.rslt_loaded_wr, 1);
        chk("done_wo_reg_en", bus.wo_reg_en, 1);
        chk("done_op_latency", bus.operation_latency_wr, 32'(wedges + redges));
        tick();
        chk("done_hold_valid", bus.operation_status_valid_wr, 1);
        chk("done_rw_en_once", bus.rw_pl2ps_reg_en, 0);
        set_flags(1'b0);
        bus.operation_start_rd = 1'b0;
        tick();
        chk("done_to_idle", bus.operation_status_idle_wr, 1);
        chk("op_wo_pulses", 32'(wo_cnt - wo0), 32'(n + 1));
        chk("op_rw_pulses", 32'(rw_cnt - rw0), 1);
    endtask

    task automatic size_err(input int idx);
        int wo0;
        wo0 = wo_cnt;
        set_sizes(32'd4, 32'd5);               // pckt > rslt when idx is out of range
        if (idx == 0) bus.data_size_rd = '0;
        if (idx == 1) bus.grid_size_rd = '0;
        if (idx == 2) bus.scle_size_rd = '0;
        if (idx == 3) begin bus.rslt_size_rd = '0; bus.pckt_size_rd = '0; end
        if (idx == 4) bus.pckt_size_rd = '0;
        bus.operation_start_rd = 1'b1;
        tick();
        chk("err_str_busy", bus.operation_status_busy_wr, 1);
        tick();
        $display("size_err idx=%0d error=%0d busy=%0d", idx, bus.operation_status_error_wr,
                 bus.operation_status_busy_wr);
        chk("err_flag", bus.operation_status_error_wr, 1);
        chk("err_busy", bus.operation_status_busy_wr, 0);
        chk("err_locked", bus.operation_status_locked_wr, 0);
        tick();
        chk("err_hold", bus.operation_status_error_wr, 1);
        bus.operation_start_rd = 1'b0;
        tick();
        chk("err_to_idle", bus.operation_status_idle_wr, 1);
        chk("err_no_wo_en", 32'(wo_cnt - wo0), 0);
    endtask

    initial begin
        set_sizes(32'd0, 32'd0);
        set_flags(1'b0);
        bus.operation_start_rd = 1'b0;
        bus.interrupt_abort = 1'b0;
        bus.interrupt_error = 1'b0;
        stream(3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idle", bus.operation_status_idle_wr, 1);
        chk("rst_busy", bus.operation_status_busy_wr, 0);
        chk("rst_valid", bus.operation_status_valid_wr, 0);
        chk("rst_error", bus.operation_status_error_wr, 0);
        chk("rst_wo_reg_en", bus.wo_reg_en, 0);
        chk("rst_op_timer", bus.operation_timer_wr, 0);
        rst = 1'b0;
        tick(); tick();

        // Two packets ten cycles apart into rslt=8, pckt=4
        gaps[0] = 2; gaps[1] = 9;
        run_op(8, 4, 2, 1'b0);
        // Saturating final packet: 4, 8, 10 with back-to-back beats
        gaps[0] = 0; gaps[1] = 0; gaps[2] = 0;
        run_op(10, 4, 0, 1'b0);
        // Flags raised one per cycle in reverse order
        gaps[0] = 3;
        run_op(4, 4, 1, 1'b1);
        // Progress sum overflowing 32 bits must clamp to the result size
        gaps[0] = 1; gaps[1] = 1;
        run_op(64'hFFFF_FFFF, 64'h8000_0000, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            longint r, p;
            r = longint'($urandom_range(12, 1));
            p = longint'($urandom_range(int'(r), 1));
            for (int k = 0; k < 16; k++) gaps[k] = int'($urandom_range(6, 0));
            run_op(r, p, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        size_err(5);
        size_err(int'($urandom_range(4, 0)));

        // Abort in RUN after one packet
        set_sizes(32'd8, 32'd4);
        bus.operation_start_rd = 1'b1;
        tick(); tick();
        set_flags(1'b1); tick();
        stream(3'b111); tick(); stream(3'b000);
        chk("abort_pre_iter", bus.operation_progress_iter_wr, 1);
        bus.interrupt_abort = 1'b1; tick(); bus.interrupt_abort = 1'b0;
        chk("abort_idle", bus.operation_status_idle_wr, 1);
        chk("abort_iter_kept", bus.operation_progress_iter_wr, 1);
        chk("abort_prog_kept", bus.operation_progress_rslt_wr, 4);
        chk("abort_no_done", bus.rw_pl2ps_reg_en, 0);
        tick();
        chk("abort_no_restart", bus.operation_status_idle_wr, 1);
        bus.operation_start_rd = 1'b0; tick();
        bus.operation_start_rd = 1'b1; tick();
        chk("restart_wo_reg_rst", bus.wo_reg_rst, 1);
        chk("restart_iter_clr", bus.operation_progress_iter_wr, 0);
        chk("restart_prog_clr", bus.operation_progress_rslt_wr, 0);
        bus.interrupt_abort = 1'b1; tick(); bus.interrupt_abort = 1'b0;
        chk("abort_in_str", bus.operation_status_idle_wr, 1);
        set_flags(1'b0); bus.operation_start_rd = 1'b0; tick();

        // Error and abort together in WAIT_LD: error wins and holds while requested
        bus.operation_start_rd = 1'b1; tick(); tick();
        bus.interrupt_error = 1'b1; bus.interrupt_abort = 1'b1; tick();
        bus.interrupt_abort = 1'b0;
        chk("irq_err_wins", bus.operation_status_error_wr, 1);
        bus.operation_start_rd = 1'b0; tick();
        chk("irq_err_held", bus.operation_status_error_wr, 1);
        bus.interrupt_error = 1'b0; tick();
        chk("irq_err_release", bus.operation_status_idle_wr, 1);

        // Asynchronous reset mid-RUN with start held high
        bus.operation_start_rd = 1'b1; tick(); tick();
        set_flags(1'b1); tick();
        stream(3'b111); tick(); stream(3'b000);
        rst = 1'b1;
        #2;
        chk("arst_idle", bus.operation_status_idle_wr, 1);
        chk("arst_busy", bus.operation_status_busy_wr, 0);
        chk("arst_prog", bus.operation_progress_rslt_wr, 0);
        chk("arst_iter", bus.operation_progress_iter_wr, 0);
        chk("arst_wo_reg_en", bus.wo_reg_en, 0);
        #1 rst = 1'b0;
        tick(); tick(); tick();
        chk("arst_no_edge", bus.operation_status_idle_wr, 1);
        bus.operation_start_rd = 1'b0; tick();
        bus.operation_start_rd = 1'b1; tick();
        chk("arst_restart", bus.operation_status_busy_wr, 1);
        bus.interrupt_abort = 1'b1; tick(); bus.interrupt_abort = 1'b0;
        bus.operation_start_rd = 1'b0; set_flags(1'b0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ccu_operation_sequencer.md
Name: ccu_operation_sequencer

Overview:
Control FSM of the CentralControlUnit, directly downstream of the CCU register file. It consumes the PS-written sizes, loaded flags, start bit and interrupts, and snoops the result AXI-Stream. It drives the register-file write strobes (rw_pl2ps_reg_en, wo_reg_en, wo_reg_rst) and the status, progress, timer and latency values written back for the PS to read.

Parameters:
CNT_WIDTH, 32, width of all progress, timer and latency counters; must equal the register-file word width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
data_size_rd/grid_size_rd/scle_size_rd/rslt_size_rd/pckt_size_rd  in  32 each  configured lengths from register file
data_loaded_rd/grid_loaded_rd/scle_loaded_rd/wght_loaded_rd  in  1 each  PS "buffer loaded" flags
operation_start_rd  in  1  PS start bit (level)
interrupt_abort  in  1  PS abort request
interrupt_error  in  1  PS forced-error request
rslt_tvalid/rslt_tready/rslt_tlast  in  1 each  snooped result stream handshake
rw_pl2ps_reg_en  out  1  one-cycle strobe writing rslt_loaded_wr/operation_done_wr
rslt_loaded_wr/operation_done_wr  out  1 each  values for that strobe
wo_reg_en  out  1  one-cycle strobe latching progress/timer/latency
wo_reg_rst  out  1  one-cycle clear of write-only registers
operation_status_idle_wr/busy_wr/error_wr/locked_wr/valid_wr  out  1 each  status bits
operation_progress_rslt_wr/operation_progress_iter_wr  out  CNT_WIDTH  results emitted / packets emitted
iteration_timer_wr/iteration_latency_wr/operation_timer_wr/operation_latency_wr  out  CNT_WIDTH  cycle counters

Behaviour:
- Reset (async, rst=1): state IDLE; all counters 0; all strobes 0; status idle=1, all other status bits 0.
- Start detect: registered rising edge of operation_start_rd. A level held high across reset does not start an operation.
- States and transitions:
  - IDLE: on start edge -> STR.
  - STR (1 cycle): wo_reg_rst=1; all counters cleared. If any size is 0 or pckt_size_rd > rslt_size_rd -> ERR, else -> WAIT_LD.
  - WAIT_LD: when all four loaded flags are 1 -> RUN; the flags may arrive in any order or together.
  - RUN: counts packets (see below). When progress_rslt >= rslt_size_rd -> DONE.
  - DONE: rw_pl2ps_reg_en=1 with rslt_loaded_wr=1 and operation_done_wr=1 for exactly the entry cycle. Stays in DONE until operation_start_rd=0, then -> IDLE.
  - ERR: stays until operation_start_rd=0 and interrupt_error=0, then -> IDLE.
- Interrupts: interrupt_abort in STR, WAIT_LD or RUN -> IDLE next cycle; counters retain their values; no done strobe. interrupt_error in any state other than IDLE -> ERR. If both are asserted, error wins.
- Status outputs (registered, decoded from state):
  - idle = IDLE
  - busy = STR, WAIT_LD or RUN
  - locked = WAIT_LD or RUN
  - valid = DONE
  - error = ERR
- Packet event: rslt_tvalid & rslt_tready & rslt_tlast while in RUN. Beats outside RUN are ignored.
- On each packet event:
  - progress_rslt += pckt_size_rd, saturating at rslt_size_rd.
  - progress_iter += 1.
  - iteration_latency <= iteration_timer + 1.
  - iteration_timer <= 0.
- iteration_timer increments each RUN cycle without a packet event.
- operation_timer increments every cycle in WAIT_LD and RUN. On entry to DONE, operation_latency <= operation_timer + 1.
- Width rule: every counter saturates at all-ones and never wraps.
- wo_reg_en is a registered pulse, 1 cycle after each packet event and 1 cycle after DONE entry, so the register file samples already-updated outputs. A packet event in the cycle preceding DONE entry yields two separate pulses.
- Reset asserted mid-RUN: outputs return to reset values immediately (asynchronous); no strobes are emitted.

Test Plan:
- Sizes data=grid=scle=4, rslt=8, pckt=4; assert start, then all loaded flags; two tlast beats 10 cycles apart -> progress_rslt 4 then 8; progress_iter 2; iteration_latency 10; one rw_pl2ps_reg_en pulse with done=1; valid=1; wo_reg_en pulses 3 times total.
- pckt_size=5, rslt_size=4 -> STR then ERR; error=1, busy=0; no wo_reg_en pulse; start=0 returns to IDLE.
- rslt=10, pckt=4, three packets -> progress_rslt 4, 8, 10 (saturated); DONE after the third packet.
- interrupt_abort in RUN after 1 packet -> IDLE; progress_iter stays 1; no done strobe; the next start edge clears all counters via wo_reg_rst.
- Loaded flags raised one per cycle in reverse order -> RUN entered only after the fourth flag; operation_timer counts the WAIT_LD cycles.
- rst pulsed mid-RUN, with start held high throughout -> all outputs reset immediately; FSM stays IDLE (no edge) until start toggles.
